// File: rtl/ntt_stage_sequencer_if.sv
// ntt_stage_sequencer_if: butterfly command/write-back bus (bf_valid/ready/radix/inverse/base/stride/stage, wb_valid); master = sequencer, slave = butterfly unit
interface ntt_stage_sequencer_if #(parameter int ADDR_WIDTH = 10);
  logic                  bf_valid;
  logic                  bf_ready;
  logic [2:0]            bf_radix;
  logic                  bf_inverse;
  logic [ADDR_WIDTH-1:0] bf_base;
  logic [ADDR_WIDTH:0]   bf_stride;
  logic [3:0]            bf_stage;
  logic                  wb_valid;
  modport master(output bf_valid, bf_radix, bf_inverse, bf_base, bf_stride, bf_stage, input bf_ready, wb_valid);
  modport slave(input bf_valid, bf_radix, bf_inverse, bf_base, bf_stride, bf_stage, output bf_ready, wb_valid);
endinterface

// File: rtl/ntt_stage_sequencer.sv
// ntt_stage_sequencer: mixed-radix NTT stage/group sequencer; clk, rst_n, i_start/i_inverse/i_cfg_* in, bf master bus, o_busy/o_done/o_err_cfg out
module ntt_stage_sequencer #(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_STAGES = 8,
  parameter int OUTS_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic                    i_inverse,
  input  logic [ADDR_WIDTH:0]     i_cfg_len,
  input  logic [3:0]              i_cfg_stages,
  input  logic [3*MAX_STAGES-1:0] i_cfg_radix,
  ntt_stage_sequencer_if.master   bf,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err_cfg
);
  localparam int PW = ADDR_WIDTH + 4;
  localparam logic [OUTS_W-1:0] OMAX = '1;
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, DRAIN, FINISH} state_t;
  state_t                  r_state;
  logic [ADDR_WIDTH:0]     r_len, r_span, r_grp, r_j, r_stride;
  logic [3:0]              r_nst, r_stage;
  logic [3*MAX_STAGES-1:0] r_rad;
  logic [PW-1:0]           r_prod;
  logic [OUTS_W-1:0]       r_outs;
  logic [ADDR_WIDTH-1:0]   r_base;
  logic [2:0]              r_radix;
  logic                    r_inv, r_valid, r_busy, r_done, r_err;
  logic [2:0]              w_rc;
  logic [PW-1:0]           w_ms, w_len;
  logic [ADDR_WIDTH:0]     w_step, w_jn;
  logic [OUTS_W-1:0]       w_onext;
  logic                    w_last, w_lerr, w_hs, w_free, w_more, w_dec, w_go;
  function automatic logic [PW-1:0] mulr(input logic [PW-1:0] s, input logic [2:0] c);
    return c == 3'd0 ? s << 1 : c == 3'd1 ? (s << 1) + s : c == 3'd2 ? s << 2 : c == 3'd3 ? (s << 2) + s : (s << 3) - s;
  endfunction
  assign w_rc    = r_rad[3*r_stage +: 3];
  assign w_ms    = mulr(r_state == LOAD ? r_prod : PW'(r_span), w_rc);
  assign w_len   = PW'(r_len);
  assign w_step  = w_ms[ADDR_WIDTH:0];
  assign w_jn    = r_j + (ADDR_WIDTH+1)'(1);
  assign w_last  = r_stage == r_nst - 4'd1;
  assign w_lerr  = r_nst == 4'd0 || r_nst > 4'(MAX_STAGES) || w_rc > 3'd4 || w_ms > w_len || (w_last && w_ms != w_len);
  assign w_hs    = r_valid && bf.bf_ready;
  assign w_free  = !r_valid || bf.bf_ready;
  assign w_more  = r_grp < r_len;
  assign w_dec   = bf.wb_valid && r_outs != '0;
  assign w_onext = r_outs + OUTS_W'(w_hs) - OUTS_W'(w_dec);
  assign w_go    = w_more && w_onext != OMAX;
  assign bf.bf_valid   = r_valid;
  assign bf.bf_radix   = r_radix;
  assign bf.bf_inverse = r_inv;
  assign bf.bf_base    = r_base;
  assign bf.bf_stride  = r_stride;
  assign bf.bf_stage   = r_stage;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_err_cfg     = r_err;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_len    <= '0;
      r_span   <= '0;
      r_grp    <= '0;
      r_j      <= '0;
      r_stride <= '0;
      r_nst    <= '0;
      r_stage  <= '0;
      r_rad    <= '0;
      r_prod   <= '0;
      r_outs   <= '0;
      r_base   <= '0;
      r_radix  <= '0;
      r_inv    <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_outs <= w_onext;
      case (r_state)
        IDLE: if (i_start) begin
          r_len   <= i_cfg_len;
          r_nst   <= i_cfg_stages;
          r_rad   <= i_cfg_radix;
          r_inv   <= i_inverse;
          r_prod  <= PW'(1);
          r_stage <= '0;
          r_busy  <= 1'b1;
          r_state <= LOAD;
        end
        LOAD: if (w_lerr) begin
          r_err   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end else if (w_last) begin
          r_stage <= '0;
          r_span  <= (ADDR_WIDTH+1)'(1);
          r_grp   <= '0;
          r_j     <= '0;
          r_state <= ISSUE;
        end else begin
          r_prod  <= w_ms;
          r_stage <= r_stage + 4'd1;
        end
        ISSUE: if (w_free) begin
          r_valid <= w_go;
          if (w_go) begin
            r_base   <= ADDR_WIDTH'(r_grp + r_j);
            r_stride <= r_span;
            r_radix  <= w_rc;
            r_j      <= w_jn < r_span ? w_jn : '0;
            r_grp    <= w_jn < r_span ? r_grp : r_grp + w_step;
          end
          if (!w_more) r_state <= DRAIN;
        end
        DRAIN: if (r_outs == '0) begin
          if (!w_last) begin
            r_stage <= r_stage + 4'd1;
            r_span  <= w_step;
            r_grp   <= '0;
            r_j     <= '0;
            r_state <= ISSUE;
          end else begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= FINISH;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// tb_ntt_stage_sequencer: scoreboard bench for ntt_stage_sequencer
module tb_ntt_stage_sequencer;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, inv = 1'b0;
  logic [10:0] len = '0;
  logic [3:0]  ns = '0;
  logic [23:0] rad = '0;
  logic        busy, done, err;
  int          n_chk = 0, n_err = 0, cyc = 0, tb_outs = 0, n_hs = 0, wb_delay = 1;
  bit          ready_pat = 1'b0, stray = 1'b0, pv = 1'b0;
  logic [3:0]  prev_stage = '0;
  logic [31:0] pp = '0;
  logic [31:0] exp_q[$];
  int          wbq[$];
  ntt_stage_sequencer_if #(.ADDR_WIDTH(10)) bf();
  ntt_stage_sequencer #(.ADDR_WIDTH(10), .MAX_STAGES(8), .OUTS_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_inverse(inv), .i_cfg_len(len),
    .i_cfg_stages(ns), .i_cfg_radix(rad), .bf(bf), .o_busy(busy), .o_done(done), .o_err_cfg(err)
  );
  wire [31:0] w_cmd = {3'b0, bf.bf_stage, bf.bf_radix, bf.bf_inverse, bf.bf_base, bf.bf_stride};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  initial begin
    bf.bf_ready = 1'b1;
    bf.wb_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bf.bf_ready = !ready_pat || (cyc % 7 >= 3);
      bf.wb_valid = stray || (wbq.size() > 0 && wbq[0] <= cyc);
      if (wbq.size() > 0 && wbq[0] <= cyc) void'(wbq.pop_front());
    end
  end
  initial forever begin
    bit hs;
    @(negedge clk);
    if (rst_n) begin
      hs = bf.bf_valid && bf.bf_ready;
      if (pv) check("hold", {bf.bf_valid, w_cmd[30:0]}, {1'b1, pp[30:0]});
      if (hs) begin
        n_hs++;
        if (bf.bf_stage != prev_stage) check("drain", 32'(tb_outs), 0);
        prev_stage = bf.bf_stage;
        check("outs_cap", 32'(tb_outs > 14), 0);
        if (exp_q.size() == 0) check("sb_extra", w_cmd, 32'hFFFF_FFFF);
        else check("cmd", w_cmd, exp_q.pop_front());
        wbq.push_back(cyc + wb_delay);
      end
      tb_outs = tb_outs + int'(hs) - int'(bf.wb_valid && tb_outs > 0);
      pv = bf.bf_valid && !bf.bf_ready;
      pp = w_cmd;
    end else pv = 1'b0;
  end
  task automatic go(input int n, input int s, input logic [23:0] r, input logic iv, input int elat, input int dly, output int c0);
    int span, rv;
    logic [2:0] code;
    wb_delay = dly;
    prev_stage = '0;
    if (elat == 0) begin
      span = 1;
      for (int k = 0; k < s; k++) begin
        code = r[3*k +: 3];
        rv = code == 0 ? 2 : code == 1 ? 3 : code == 2 ? 4 : code == 3 ? 5 : 7;
        for (int g = 0; g < n; g += rv * span)
          for (int j = 0; j < span; j++)
            exp_q.push_back({3'b0, 4'(k), code, iv, 10'(g + j), 11'(span)});
        span *= rv;
      end
    end
    @(posedge clk);
    #1;
    len = 11'(n); ns = 4'(s); rad = r; inv = iv; start = 1'b1; c0 = cyc;
    @(posedge clk);
    #1;
    start = 1'b0; len = '0; ns = '0; rad = '0; inv = 1'b0;
  endtask
  task automatic run(input int n, input int s, input logic [23:0] r, input logic iv, input int elat, input int dly);
    int c0, t;
    go(n, s, r, iv, elat, dly, c0);
    t = 0;
    while (!bf.bf_valid && !err && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (elat != 0) begin
      check("err_lat", 32'(cyc - c0), 32'(elat));
      check("err_flags", {29'b0, err, busy, bf.bf_valid}, 32'b100);
      @(negedge clk);
      check("err_pulse", {31'b0, err}, 0);
      repeat (5) @(negedge clk);
      check("err_idle", {30'b0, busy, bf.bf_valid}, 0);
    end else begin
      check("lat", 32'(cyc - c0), 32'(s + 2));
      check("busy", {31'b0, busy}, 1);
      t = 0;
      while (!done && t < 5000) begin
        @(negedge clk);
        t++;
      end
      check("done", {31'b0, done}, 1);
      check("sb_empty", 32'(exp_q.size()), 0);
      check("outs_end", 32'(tb_outs), 0);
      @(negedge clk);
      check("done_pulse", {30'b0, done, busy}, 0);
    end
  endtask
  initial begin
    int c0, t, h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd", w_cmd, 0);
    check("rst_ctl", {28'b0, bf.bf_valid, busy, done, err}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(15, 2, 24'o31, 1'b0, 0, 1);
    run(8, 2, 24'o20, 1'b1, 0, 1);
    run(16, 2, 24'o31, 1'b0, 3, 1);
    run(8, 1, 24'o5, 1'b0, 2, 1);
    run(8, 0, 24'o0, 1'b0, 2, 1);
    run(8, 9, 24'o0, 1'b0, 2, 1);
    run(6, 2, 24'o02, 1'b0, 3, 1);
    run(10, 2, 24'o03, 1'b1, 0, 1);
    ready_pat = 1'b1;
    run(32, 3, 24'o220, 1'b0, 0, 1);
    ready_pat = 1'b0;
    run(15, 2, 24'o31, 1'b0, 0, 10);
    run(32, 5, 24'o0, 1'b1, 0, 40);
    @(negedge clk) stray = 1'b1;
    @(negedge clk) stray = 1'b0;
    run(12, 2, 24'o12, 1'b0, 0, 1);
    h0 = n_hs;
    go(32, 5, 24'o0, 1'b1, 0, 1, c0);
    t = 0;
    while (n_hs < h0 + 3 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("abort_issue", {31'b0, busy}, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    wbq.delete();
    tb_outs = 0;
    @(negedge clk);
    check("abort_cmd", w_cmd, 0);
    check("abort_ctl", {28'b0, bf.bf_valid, busy, done, err}, 0);
    run(7, 1, 24'o4, 1'b0, 0, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
